// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions and counter state type for the display/counter paths.
// Segment codes are active-low, bit6=g .. bit0=a.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_L     = 7'b1000111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_U     = 7'b1000001;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {IDLE, RUN, DONE} cnt_state_t;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bin3_to_seg7.sv
// Combinational 10-bit binary to three active-low 7-segment digits (leading zeros shown).
// Inputs above 999 are clamped so the display never shows a wrapped value.
module bin3_to_seg7
    import seg7_pkg::*;
(
    input  logic [9:0] i_bin,
    output logic [6:0] o_seg_centenas,
    output logic [6:0] o_seg_decenas,
    output logic [6:0] o_seg_unidades
);

    logic [9:0]  w_clamped;
    logic [11:0] w_bcd;

    // Double-dabble: adjust each BCD nibble, then shift in the next binary bit, MSB first.
    always_comb begin
        w_clamped = (i_bin > 10'd999) ? 10'd999 : i_bin;
        w_bcd     = '0;
        for (int i = 9; i >= 0; i--) begin
            if (w_bcd[3:0] >= 4'd5)  w_bcd[3:0]  = w_bcd[3:0] + 4'd3;
            if (w_bcd[7:4] >= 4'd5)  w_bcd[7:4]  = w_bcd[7:4] + 4'd3;
            if (w_bcd[11:8] >= 4'd5) w_bcd[11:8] = w_bcd[11:8] + 4'd3;
            w_bcd = {w_bcd[10:0], w_clamped[i]};
        end
    end

    assign o_seg_centenas = bcd_to_seg(w_bcd[11:8]);
    assign o_seg_decenas  = bcd_to_seg(w_bcd[7:4]);
    assign o_seg_unidades = bcd_to_seg(w_bcd[3:0]);

endmodule

// File: rtl/step_counter_unit.sv
// Select-started counting unit: advances by STEP on a tick or button edge, saturates at LIMIT.
//   state | meaning
//   IDLE  | waiting for a select rising edge; last count stays displayed
//   RUN   | counting; select low aborts back to IDLE
//   DONE  | LIMIT reached; held until select drops
module step_counter_unit
    import seg7_pkg::*;
#(
    parameter int STEP     = 1,
    parameter int LIMIT    = 100,
    parameter int MANUAL   = 0,
    parameter int TICK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_select,
    input  logic       i_step_btn,
    output logic [6:0] o_seg_centenas,
    output logic [6:0] o_seg_decenas,
    output logic [6:0] o_seg_unidades,
    output logic       o_count_reached,
    output logic [4:0] o_led,
    output logic       o_busy
);

    localparam int               DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [10:0]      STEP_X   = 11'(STEP);
    localparam logic [10:0]      LIMIT_X  = 11'(LIMIT);
    localparam logic [9:0]       LIMIT_C  = 10'(LIMIT);

    cnt_state_t       r_state, w_state_nxt;
    logic [9:0]       r_count, w_count_nxt;
    logic [DIV_W-1:0] r_div, w_div_nxt;
    logic             r_select_q;
    logic             r_btn_q;
    logic             r_count_reached, w_reached_nxt;
    logic             r_busy;

    logic             w_start;
    logic             w_tick;
    logic             w_press;
    logic             w_advance;
    logic [10:0]      w_sum;

    assign w_start   = i_select & ~r_select_q;
    assign w_tick    = (r_div == DIV_LAST);
    assign w_press   = i_step_btn & ~r_btn_q;
    assign w_advance = (MANUAL != 0) ? w_press : w_tick;
    assign w_sum     = {1'b0, r_count} + STEP_X;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= IDLE;
            r_count         <= '0;
            r_div           <= '0;
            r_select_q      <= 1'b0;
            r_btn_q         <= 1'b0;
            r_count_reached <= 1'b0;
            r_busy          <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_count         <= w_count_nxt;
            r_div           <= w_div_nxt;
            r_select_q      <= i_select;
            r_btn_q         <= i_step_btn;
            r_count_reached <= w_reached_nxt;
            r_busy          <= (w_state_nxt == RUN);
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_count_nxt   = r_count;
        w_div_nxt     = r_div;
        w_reached_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_state_nxt = RUN;
                    w_count_nxt = '0;
                    w_div_nxt   = '0;
                end
            end
            RUN: begin
                // Abort takes priority over an advance landing in the same cycle.
                if (!i_select) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_div_nxt = w_tick ? '0 : r_div + DIV_W'(1);
                    if (w_advance) begin
                        if (w_sum >= LIMIT_X) begin
                            w_count_nxt   = LIMIT_C;
                            w_reached_nxt = 1'b1;
                            w_state_nxt   = DONE;
                        end else begin
                            w_count_nxt = w_sum[9:0];
                        end
                    end
                end
            end
            DONE: begin
                if (!i_select) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    for (genvar i = 0; i < 5; i++) begin : g_led
        localparam logic [9:0] THRESH = 10'(((i + 1) * LIMIT) / 5);
        assign o_led[i] = (r_count >= THRESH);
    end

    bin3_to_seg7 u_disp (
        .i_bin          (r_count),
        .o_seg_centenas (o_seg_centenas),
        .o_seg_decenas  (o_seg_decenas),
        .o_seg_unidades (o_seg_unidades)
    );

    assign o_count_reached = r_count_reached;
    assign o_busy          = r_busy;

endmodule

// File: tb/tb_step_counter_unit.sv
// Bench for step_counter_unit: four configurations, scoreboard of expected display/pulse events.
// Expected events come from arithmetic on STEP/LIMIT/TICK_DIV, checked by an independent monitor.
module tb_step_counter_unit;

    localparam int T = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] sel;
    logic [3:0] btn;
    logic [6:0] seg_c [4];
    logic [6:0] seg_d [4];
    logic [6:0] seg_u [4];
    logic [4:0] led_o [4];
    logic [3:0] reached;
    logic [3:0] busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int unit;
        int cyc;
        int val;
        bit rch;
        bit bsy;
    } ev_t;

    ev_t sbq[$];
    int  model_val [4];
    int  last_val  [4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    step_counter_unit #(.STEP(1),  .LIMIT(5),   .MANUAL(0), .TICK_DIV(T)) u0 (
        .clk(clk), .reset(reset), .i_select(sel[0]), .i_step_btn(btn[0]),
        .o_seg_centenas(seg_c[0]), .o_seg_decenas(seg_d[0]), .o_seg_unidades(seg_u[0]),
        .o_count_reached(reached[0]), .o_led(led_o[0]), .o_busy(busy[0]));
    step_counter_unit #(.STEP(4),  .LIMIT(10),  .MANUAL(0), .TICK_DIV(T)) u1 (
        .clk(clk), .reset(reset), .i_select(sel[1]), .i_step_btn(btn[1]),
        .o_seg_centenas(seg_c[1]), .o_seg_decenas(seg_d[1]), .o_seg_unidades(seg_u[1]),
        .o_count_reached(reached[1]), .o_led(led_o[1]), .o_busy(busy[1]));
    step_counter_unit #(.STEP(10), .LIMIT(30),  .MANUAL(1), .TICK_DIV(T)) u2 (
        .clk(clk), .reset(reset), .i_select(sel[2]), .i_step_btn(btn[2]),
        .o_seg_centenas(seg_c[2]), .o_seg_decenas(seg_d[2]), .o_seg_unidades(seg_u[2]),
        .o_count_reached(reached[2]), .o_led(led_o[2]), .o_busy(busy[2]));
    step_counter_unit #(.STEP(1),  .LIMIT(100), .MANUAL(0), .TICK_DIV(T)) u3 (
        .clk(clk), .reset(reset), .i_select(sel[3]), .i_step_btn(btn[3]),
        .o_seg_centenas(seg_c[3]), .o_seg_decenas(seg_d[3]), .o_seg_unidades(seg_u[3]),
        .o_count_reached(reached[3]), .o_led(led_o[3]), .o_busy(busy[3]));

    function automatic int p_step(int u);
        case (u)
            0: return 1;
            1: return 4;
            2: return 10;
            default: return 1;
        endcase
    endfunction

    function automatic int p_lim(int u);
        case (u)
            0: return 5;
            1: return 10;
            2: return 30;
            default: return 100;
        endcase
    endfunction

    function automatic int seg2dig(logic [6:0] s);
        case (s)
            7'b1000000: return 0;
            7'b1111001: return 1;
            7'b0100100: return 2;
            7'b0110000: return 3;
            7'b0011001: return 4;
            7'b0010010: return 5;
            7'b0000010: return 6;
            7'b1111000: return 7;
            7'b0000000: return 8;
            7'b0010000: return 9;
            default:    return -1;
        endcase
    endfunction

    function automatic int disp_val(int u);
        int c, d, n;
        c = seg2dig(seg_c[u]);
        d = seg2dig(seg_d[u]);
        n = seg2dig(seg_u[u]);
        if (c < 0 || d < 0 || n < 0) return -1;
        return c * 100 + d * 10 + n;
    endfunction

    // Progress bar: one LED per fifth of the way to LIMIT.
    function automatic logic [4:0] led_exp(int v, int lim);
        logic [4:0] l;
        for (int i = 0; i < 5; i++) l[i] = (v >= ((i + 1) * lim) / 5);
        return l;
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(int u, int c, int v, bit r, bit b);
        ev_t e;
        e.unit = u; e.cyc = c; e.val = v; e.rch = r; e.bsy = b;
        sbq.push_back(e);
    endtask

    task automatic cycles(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic step_to(int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Raise select now; the start edge is the next clock. Advance j lands TICK_DIV*j later.
    task automatic start_auto(int u, int nmax, output int e_out);
        int e, s, lim, v;
        e      = cyc + 1;
        sel[u] = 1'b1;
        if (model_val[u] != 0) push(u, e, 0, 1'b0, 1'b1);
        model_val[u] = 0;
        s   = p_step(u);
        lim = p_lim(u);
        for (int j = 1; j <= nmax; j++) begin
            v = (j * s >= lim) ? lim : j * s;
            push(u, e + j * T, v, v == lim, v != lim);
            model_val[u] = v;
            if (v == lim) break;
        end
        e_out = e;
    endtask

    // Monitor: any display change or pulse is a DUT event and must match the queue head.
    always @(negedge clk) begin
        for (int u = 0; u < 4; u++) begin
            int  v;
            ev_t e;
            v = disp_val(u);
            if (v != last_val[u] || reached[u]) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: unit %0d value %0d pulse %0d at cycle %0d, nothing expected",
                             u, v, reached[u], cyc);
                end else begin
                    e = sbq.pop_front();
                    check("ev_unit",    u,          e.unit);
                    check("ev_cycle",   cyc,        e.cyc);
                    check("ev_value",   v,          e.val);
                    check("ev_reached", reached[u], e.rch);
                    check("ev_busy",    busy[u],    e.bsy);
                    check("ev_led",     led_o[u],   led_exp(e.val, p_lim(e.unit)));
                end
                last_val[u] = v;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int e, j, r;
        sel   = '0;
        btn   = '0;
        reset = 1'b1;
        for (int u = 0; u < 4; u++) begin
            model_val[u] = 0;
            last_val[u]  = 0;
        end
        @(posedge clk);
        #1;
        cycles(2);
        check("rst_seg_c", seg_c[0], 7'b1000000);
        check("rst_seg_d", seg_d[0], 7'b1000000);
        check("rst_seg_u", seg_u[0], 7'b1000000);
        check("rst_led",   led_o[0], 0);
        check("rst_busy",  busy,     0);
        check("rst_pulse", reached,  0);
        reset = 1'b0;
        cycles(2);

        // STEP=1 LIMIT=5: one advance per tick, pulse at 5, display "005".
        start_auto(0, 99, e);
        step_to(e + 5 * T);
        check("done_seg_c", seg_c[0], 7'b1000000);
        check("done_seg_d", seg_d[0], 7'b1000000);
        check("done_seg_u", seg_u[0], 7'b0010010);
        check("done_led",   led_o[0], 5'b11111);
        check("done_pulse", reached[0], 1);
        cycles(1);
        check("pulse_width", reached[0], 0);
        check("done_busy",   busy[0],    0);

        // Select held through DONE for 20 ticks: no restart, then toggle restarts from 0.
        cycles(20 * T);
        check("done_hold_busy", busy[0], 0);
        check("done_hold_val",  disp_val(0), 5);
        sel[0] = 1'b0;
        cycles(2);
        start_auto(0, 99, e);
        step_to(e + 5 * T + 2);
        sel[0] = 1'b0;
        cycles(2);

        // STEP=4 LIMIT=10: 4, 8, then saturate at 10.
        start_auto(1, 99, e);
        step_to(e + 3 * T + 20);
        check("sat_hold_busy", busy[1], 0);
        check("sat_hold_val",  disp_val(1), 10);
        sel[1] = 1'b0;
        cycles(2);

        // Random runs with aborts at random points, including the abort-vs-advance collision.
        for (int it = 0; it < 8; it++) begin
            j = $urandom_range(0, 3);
            r = $urandom_range(0, T - 1);
            start_auto(1, (j == 3) ? 99 : j, e);
            if (j == 3) step_to(e + 3 * T + 1);
            else        step_to(e + j * T + r);
            sel[1] = 1'b0;
            cycles($urandom_range(2, 5));
            check("abort_busy", busy[1], 0);
            check("abort_hold", disp_val(1), model_val[1]);
        end

        // Manual STEP=10 LIMIT=30: button held across the start edge must not count.
        btn[2] = 1'b1;
        cycles(2);
        sel[2] = 1'b1;
        cycles(6);
        check("held_btn_val",  disp_val(2), 0);
        check("held_btn_busy", busy[2], 1);
        btn[2] = 1'b0;
        cycles($urandom_range(1, 3));
        for (int k = 1; k <= 3; k++) begin
            btn[2] = 1'b1;
            push(2, cyc + 1, 10 * k, k == 3, k != 3);
            cycles($urandom_range(1, 3));
            btn[2] = 1'b0;
            cycles($urandom_range(1, 4));
        end
        model_val[2] = 30;
        sel[2] = 1'b0;
        cycles(2);

        // LIMIT=100: abort at 37, display holds "037", then restart from 0.
        start_auto(3, 37, e);
        step_to(e + 37 * T);
        sel[3] = 1'b0;
        cycles(1);
        check("abort37_busy", busy[3], 0);
        check("abort37_val",  disp_val(3), 37);
        check("abort37_c",    seg_c[3], 7'b1000000);
        check("abort37_d",    seg_d[3], 7'b0110000);
        check("abort37_u",    seg_u[3], 7'b1111000);
        cycles(2);
        start_auto(3, 3, e);
        step_to(e + 3 * T);
        @(negedge clk);
        #1;

        // Reset mid-run at count 3: every unit drops to reset values at once.
        reset  = 1'b1;
        sel[3] = 1'b0;
        for (int u = 0; u < 4; u++) begin
            if (model_val[u] != 0) push(u, cyc + 1, 0, 1'b0, 1'b0);
            model_val[u] = 0;
        end
        #1;
        check("rst_mid_busy",  busy[3],    0);
        check("rst_mid_pulse", reached[3], 0);
        check("rst_mid_val",   disp_val(3), 0);
        check("rst_mid_led",   led_o[3],   0);
        cycles(2);
        reset = 1'b0;
        cycles(20);
        check("idle_after_rst", busy[3], 0);
        start_auto(3, 4, e);
        step_to(e + 4 * T + 1);
        sel[3] = 1'b0;
        cycles(3);

        check("queue_empty", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/step_counter_unit.md
Name: step_counter_unit

Overview:
Responder end of the counter-select interface: a single parameterised counting unit that is started by a level `select` from the counter selector. It counts up by STEP, paced by an internal 1 Hz tick (automatic) or by a debounced step button (manual). It returns a one-cycle `count_reached` pulse at LIMIT and drives three active-low 7-segment digits plus a 5-LED progress bar. One instance per counter slot replaces the per-slot hand-written counters.

Parameters:
STEP, 1, increment per advance event (1..999)
LIMIT, 100, terminal count (STEP..999)
MANUAL, 0, 0 = advance on internal tick, 1 = advance on step_btn rising edge
TICK_DIV, 50_000_000, clk cycles per automatic tick (1 Hz at 50 MHz; benches use 4)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
select  in  1  level from selector; high = this unit active
step_btn  in  1  debounced manual step level; ignored when MANUAL=0
seg_centenas  out  7  hundreds digit, active-low, bit6=g .. bit0=a
seg_decenas  out  7  tens digit, same encoding
seg_unidades  out  7  units digit, same encoding
count_reached  out  1  one-cycle pulse when count reaches LIMIT
led  out  5  thermometer progress bar
busy  out  1  high in RUN state

Behaviour:
- Reset (async, active-high): state=IDLE, count=0, tick divider=0, select_q=0, btn_q=0, count_reached=0, busy=0, led=0, digits show "000" (7'b1000000 each).
- State machine states: IDLE, RUN, DONE. `select_q` is the registered select; start = select & ~select_q.
- IDLE, on start: count<=0, divider<=0, go to RUN. Any other input: stay in IDLE and keep count (the last result stays displayed).
- RUN: busy=1. Advance event, automatic mode: the divider reaches TICK_DIV-1, then wraps to 0. The first advance comes TICK_DIV cycles after the start edge.
- RUN: advance event, manual mode: step_btn & ~btn_q. btn_q is sampled every cycle, so a button held across start does not count.
- On an advance: if count+STEP >= LIMIT, count<=LIMIT (saturate, never overshoot), count_reached<=1 for exactly one cycle, go to DONE. Otherwise count<=count+STEP.
- RUN, select low (abort): go to IDLE the next cycle, count held, no count_reached. Abort wins over an advance in the same cycle.
- DONE: count held at LIMIT. Stays in DONE while select is high, and goes to IDLE when select is low. The selector drops select in response to the pulse, so no re-trigger happens without a fresh rising edge.
- A select that stays high in DONE never restarts the unit. A restart needs a low-then-high edge.
- count width is 10 bits. The intermediate sum is 11 bits to avoid wrap.
- led[i] = (count >= ((i+1)*LIMIT)/5), with thresholds computed at elaboration, for i=0..4. LIMIT gives 5'b11111.
- Digits: count is converted by double-dabble to BCD, then to 7-seg. The display is purely combinational from the count register. Leading zeros are shown.
- count_reached and busy are registered. Digit and led outputs have 0 cycles of latency from count.
- Reset during RUN: immediate return to reset values with no pulse.

Decomposition:
- Shared package seg7_pkg holds:
  - digit codes SEG_0..SEG_9 (active-low)
  - letter codes SEG_L, SEG_E, SEG_U
  - SEG_BLANK = 7'b1111111
  - typedef enum logic [1:0] {IDLE, RUN, DONE} cnt_state_t
- One sub-module, bin3_to_seg7: 10-bit binary in, three 7-bit segment outputs, combinational, values clamped to 999. It is reused by other display paths.

Test Plan:
- TICK_DIV=4, STEP=1, LIMIT=5, auto: pulse select high and hold.
  - Expect count 1,2,3,4,5 at cycles 4,8,12,16,20 after the edge.
  - Expect count_reached high for exactly 1 cycle at 5, with led=5'b11111 and digits 000,005.
- STEP=4, LIMIT=10, auto: expect count sequence 4,8,10 (saturated, never 12), count_reached once, and DONE held while select is high.
- MANUAL=1, STEP=10, LIMIT=30:
  - Hold step_btn high across the select edge and expect no count.
  - Then give 3 clean press/release pulses and expect 10,20,30 with count_reached on the third.
- Auto, LIMIT=100: drop select at count=37. Expect IDLE next cycle, count held at 37, digits "037", no pulse. Re-raise select and expect count restarting from 0.
- Assert reset mid-RUN at count=3. Expect all outputs at reset values in the same cycle, no count_reached, and after release the unit idles until a new select edge.
- Hold select high through DONE for 20 ticks. Expect no further pulses and no restart. A low-high toggle of select restarts from 0.
